// File: rtl/regfile_rd2_if.sv
// Operand-read and writeback bus of the two-read, one-write register file.
// master is the decode/writeback side, slave is the register file.
interface regfile_rd2_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             rd_req;
  logic             stall;
  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             rd_valid;
  logic             wen;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;

  modport master (
    output rd_req, stall, ra1, ra2, wen, wa, wd,
    input  rd1, rd2, rd_valid
  );

  modport slave (
    input  rd_req, stall, ra1, ra2, wen, wa, wd,
    output rd1, rd2, rd_valid
  );
endinterface

// File: rtl/regfile_rd2.sv
// Two-read, one-write register file with registered operands; entry 0 reads zero.
// Define REGFILE_BYPASS_EN to forward same-edge write data to a matching read.
module regfile_rd2 #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic         clk,
  input  logic         rst,
  regfile_rd2_if.slave bus
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the array is built from resettable flops so it clears asynchronously; a RAM macro could not honour this.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.wen && bus.wa != '0) begin
      // NOTE: non-blocking so a read captured on this same edge sees the pre-write entry.
      mem[bus.wa] <= bus.wd;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns both values and no latch is inferred.
    val1 = '0;
    val2 = '0;
    if (bus.ra1 != '0) val1 = mem[bus.ra1];
    if (bus.ra2 != '0) val2 = mem[bus.ra2];
`ifdef REGFILE_BYPASS_EN
    if (bus.wen && bus.wa != '0 && bus.wa == bus.ra1) val1 = bus.wd;
    if (bus.wen && bus.wa != '0 && bus.wa == bus.ra2) val2 = bus.wd;
`endif
  end

  // Stall freezes the whole operand stage; an idle cycle only drops valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rd1      <= '0;
      bus.rd2      <= '0;
      bus.rd_valid <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.rd_req) begin
        bus.rd1      <= val1;
        bus.rd2      <= val2;
        bus.rd_valid <= 1'b1;
      end else begin
        bus.rd_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_rd2.sv
// Self-checking bench for regfile_rd2: directed scenarios plus randomized traffic
// against an array-based reference model.
module tb_regfile_rd2;
  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [WIDTH-1:0] model [DEPTH];
  logic [WIDTH-1:0] exp_rd1 = '0;
  logic [WIDTH-1:0] exp_rd2 = '0;
  logic             exp_valid = 1'b0;

  regfile_rd2_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  regfile_rd2 #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_val(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wen && bus.wa == a) return bus.wd;
`endif
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_rd1 = '0;
    exp_rd2 = '0;
    exp_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.rd_req = 1'b0; bus.stall = 1'b0; bus.ra1 = '0; bus.ra2 = '0;
    bus.wen = 1'b0; bus.wa = '0; bus.wd = '0;
  endtask

  // Advance one clock with rst high, updating the expected outputs and the model.
  task automatic tick();
    if (!bus.stall) begin
      if (bus.rd_req) begin
        exp_rd1 = ref_val(bus.ra1);
        exp_rd2 = ref_val(bus.ra2);
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
    end
    if (bus.wen && bus.wa != 0) model[bus.wa] = bus.wd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.rd_req = 1'b1; bus.stall = 1'($urandom_range(0, 1));
      bus.ra1 = AW'($urandom); bus.ra2 = AW'($urandom);
      bus.wen = 1'b1; bus.wa = AW'($urandom); bus.wd = $urandom;
      @(posedge clk);
      #1;
      tests++;
      if (bus.rd1 !== '0 || bus.rd2 !== '0 || bus.rd_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold: rd1=%h rd2=%h valid=%b, required 0/0/0", bus.rd1, bus.rd2, bus.rd_valid);
      end
    end
    idle_inputs();
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_req = 1'b1; bus.ra1 = AW'(i); bus.ra2 = AW'(DEPTH - 1 - i);
      tick();
      tests++;
      if (bus.rd1 !== '0 || bus.rd2 !== '0 || bus.rd_valid !== 1'b1) begin
        fails++;
        $display("FAIL reset_contents[%0d]: rd1=%h rd2=%h valid=%b, required 0/0/1", i, bus.rd1, bus.rd2, bus.rd_valid);
      end
    end
    idle_inputs();
  endtask

  task automatic test_basic();
    bus.wen = 1'b1; bus.wa = 5'd5; bus.wd = 32'hDEAD_BEEF;
    tick();
    bus.wen = 1'b0; bus.rd_req = 1'b1; bus.ra1 = 5'd5; bus.ra2 = 5'd0;
    tick();
    tests++;
    if (bus.rd1 !== 32'hDEAD_BEEF || bus.rd2 !== '0 || bus.rd_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic_rw: rd1=%h rd2=%h valid=%b, required deadbeef/0/1", bus.rd1, bus.rd2, bus.rd_valid);
    end
    bus.rd_req = 1'b0;
    tick();
    tests++;
    if (bus.rd_valid !== 1'b0 || bus.rd1 !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL idle_drop_valid: rd1=%h valid=%b, required deadbeef/0", bus.rd1, bus.rd_valid);
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    bus.wen = 1'b1; bus.wa = 5'd0; bus.wd = 32'h1234_5678;
    bus.rd_req = 1'b1; bus.ra1 = 5'd0; bus.ra2 = 5'd0;
    tick();
    tests++;
    if (bus.rd1 !== '0 || bus.rd2 !== '0) begin
      fails++;
      $display("FAIL zero_same_edge: rd1=%h rd2=%h, required 0/0", bus.rd1, bus.rd2);
    end
    bus.wen = 1'b0;
    tick();
    tests++;
    if (bus.rd1 !== '0 || bus.rd_valid !== 1'b1) begin
      fails++;
      $display("FAIL zero_reg: rd1=%h valid=%b, required 0/1", bus.rd1, bus.rd_valid);
    end
    idle_inputs();
  endtask

  task automatic test_raw();
    logic [WIDTH-1:0] want;
`ifdef REGFILE_BYPASS_EN
    want = 32'h2;
`else
    want = 32'h1;
`endif
    bus.wen = 1'b1; bus.wa = 5'd7; bus.wd = 32'h1;
    tick();
    bus.wd = 32'h2; bus.rd_req = 1'b1; bus.ra1 = 5'd7; bus.ra2 = 5'd7;
    tick();
    tests++;
    if (bus.rd1 !== want || bus.rd2 !== want) begin
      fails++;
      $display("FAIL same_edge_raw: rd1=%h rd2=%h, required %h", bus.rd1, bus.rd2, want);
    end
    bus.wen = 1'b0;
    tick();
    tests++;
    if (bus.rd1 !== 32'h2 || bus.rd2 !== 32'h2) begin
      fails++;
      $display("FAIL raw_next_cycle: rd1=%h rd2=%h, required 2", bus.rd1, bus.rd2);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    bus.wen = 1'b1; bus.wa = 5'd3; bus.wd = 32'hA;
    tick();
    bus.wen = 1'b0; bus.rd_req = 1'b1; bus.ra1 = 5'd3; bus.ra2 = 5'd5;
    tick();
    tests++;
    if (bus.rd1 !== 32'hA || bus.rd_valid !== 1'b1) begin
      fails++;
      $display("FAIL stall_setup: rd1=%h valid=%b, required a/1", bus.rd1, bus.rd_valid);
    end
    for (int c = 0; c < 3; c++) begin
      bus.stall = 1'b1; bus.wen = 1'b1; bus.wa = 5'd3; bus.wd = 32'hB;
      bus.rd_req = 1'($urandom_range(0, 1)); bus.ra1 = AW'($urandom);
      tick();
      tests++;
      if (bus.rd1 !== 32'hA || bus.rd2 !== 32'hDEAD_BEEF || bus.rd_valid !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold[%0d]: rd1=%h rd2=%h valid=%b, required a/deadbeef/1", c, bus.rd1, bus.rd2, bus.rd_valid);
      end
    end
    bus.stall = 1'b0; bus.wen = 1'b0; bus.rd_req = 1'b1; bus.ra1 = 5'd3;
    tick();
    tests++;
    if (bus.rd1 !== 32'hB || bus.rd_valid !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: rd1=%h valid=%b, required b/1", bus.rd1, bus.rd_valid);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.wen    = ($urandom_range(0, 3) != 0);
      bus.wa     = AW'($urandom);
      bus.wd     = $urandom;
      bus.stall  = ($urandom_range(0, 7) == 0);
      bus.rd_req = ($urandom_range(0, 4) != 0);
      bus.ra1    = ($urandom_range(0, 2) == 0) ? bus.wa : AW'($urandom);
      bus.ra2    = ($urandom_range(0, 3) == 0) ? bus.ra1 : AW'($urandom);
      if ($urandom_range(0, 9) == 0) bus.wa = '0;
      tick();
      tests++;
      if (bus.rd1 !== exp_rd1 || bus.rd2 !== exp_rd2 || bus.rd_valid !== exp_valid) begin
        fails++;
        $display("FAIL random[%0d]: rd1=%h rd2=%h valid=%b, required %h/%h/%b",
                 c, bus.rd1, bus.rd2, bus.rd_valid, exp_rd1, exp_rd2, exp_valid);
      end
    end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    bus.wen = 1'b1; bus.wa = 5'd9; bus.wd = 32'hCAFE_F00D;
    tick();
    bus.wen = 1'b0; bus.rd_req = 1'b1; bus.ra1 = 5'd9; bus.ra2 = 5'd5;
    tick();
    tests++;
    if (bus.rd1 !== 32'hCAFE_F00D || bus.rd_valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_setup: rd1=%h valid=%b, required cafef00d/1", bus.rd1, bus.rd_valid);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (bus.rd1 !== '0 || bus.rd2 !== '0 || bus.rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_async: rd1=%h rd2=%h valid=%b, required 0/0/0", bus.rd1, bus.rd2, bus.rd_valid);
    end
    idle_inputs();
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_req = 1'b1; bus.ra1 = AW'(i); bus.ra2 = AW'((i + 1) % DEPTH);
      tick();
      tests++;
      if (bus.rd1 !== '0 || bus.rd2 !== '0 || bus.rd_valid !== 1'b1) begin
        fails++;
        $display("FAIL mid_reset_contents[%0d]: rd1=%h rd2=%h valid=%b, required 0/0/1", i, bus.rd1, bus.rd2, bus.rd_valid);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    clear_model();
    #2;
    tests++;
    if (bus.rd1 !== '0 || bus.rd2 !== '0 || bus.rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_initial: rd1=%h rd2=%h valid=%b, required 0/0/0", bus.rd1, bus.rd2, bus.rd_valid);
    end
    test_reset();
    test_basic();
    test_zero_reg();
    test_raw();
    test_stall();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
